writeback_arbiter: RTL and testbench

Merges the two register-write sources of the pipelined core onto the single write port of the 32x32 register file. The sources are the in-order pipeline writeback and the long-latency multiply/divide unit. It buffers multdiv results and holds a per-register pending scoreboard. From that scoreboard it drives a decode-stage stall, so no instruction reads a register whose multdiv result has not yet been written. It sits directly upstream of the register file's write port (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`).

---
 rtl/writeback_arbiter_pkg.sv | 19 +
 rtl/writeback_arbiter_fifo.sv | 52 +++++
 rtl/writeback_arbiter.sv | 127 ++++++++++++
 tb/tb_writeback_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: write-source select
// and the buffered multdiv result entry.
package wb_pkg;

   localparam int unsigned NUM_REGS = 32;
   localparam logic [4:0]  REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_PIPE,
      SRC_MD
   } wb_src_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Small synchronous FIFO holding multdiv results that lost arbitration to the
// pipeline; depth must be a power of two so the pointers wrap naturally.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      push_i,
   input  wb_entry_t data_i,
   input  logic      pop_i,
   output wb_entry_t head_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_entry_t       mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic            push_ok, pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: occupancy is tracked by count_q alone.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges pipeline writeback and multdiv results onto the register-file write
// port, tracking pending multdiv destinations to stall decode.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned NUM_REGS   = wb_pkg::NUM_REGS
) (
   input  logic        clock,
   input  logic        ctrl_resetn,
   input  logic        pipe_wen,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   input  logic        md_issue,
   input  logic [4:0]  md_issue_rd,
   input  logic        md_valid,
   input  logic [4:0]  md_rd,
   input  logic [31:0] md_data,
   output logic        md_ready,
   input  logic        dec_valid,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [4:0]  dec_rd,
   output logic        dec_stall,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic        err_waw
);

   logic                pipe_sel, md_accept, md_keep, bypass;
   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
   wb_entry_t           fifo_head, md_entry, md_wr;
   wb_src_t             src;
   logic [NUM_REGS-1:0] pend_q, pend_d;
   logic                we_q, we_d;
   logic [4:0]          wreg_q, wreg_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                err_q, err_d;

   assign md_ready  = ctrl_resetn & ~fifo_full;
   assign md_accept = md_valid & md_ready;
   // r0 results are accepted but dropped here so they never buffer or write.
   assign md_keep   = md_accept & (md_rd != REG_ZERO);
   assign pipe_sel  = pipe_wen & (pipe_rd != REG_ZERO);
   assign md_entry  = '{rd: md_rd, data: md_data};
   assign md_wr     = bypass ? md_entry : fifo_head;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (ctrl_resetn),
      .push_i  (fifo_push),
      .data_i  (md_entry),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      src      = SRC_NONE;
      bypass   = 1'b0;
      fifo_pop = 1'b0;
      if (pipe_sel) begin
         src = SRC_PIPE;
      end else if (!fifo_empty) begin
         src      = SRC_MD;
         fifo_pop = 1'b1;
      end else if (md_keep) begin
         src    = SRC_MD;
         bypass = 1'b1;
      end
      fifo_push = md_keep & ~bypass;
   end

   always_comb begin
      we_d    = 1'b0;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      case (src)
         SRC_PIPE: begin
            we_d    = 1'b1;
            wreg_d  = pipe_rd;
            wdata_d = pipe_data;
         end
         SRC_MD: begin
            we_d    = 1'b1;
            wreg_d  = md_wr.rd;
            wdata_d = md_wr.data;
         end
         default: ;
      endcase
   end

   // Issue is applied after the clear so a same-edge set/clear leaves it set.
   always_comb begin
      pend_d = pend_q;
      if (src == SRC_MD) pend_d[md_wr.rd] = 1'b0;
      if (md_issue && (md_issue_rd != REG_ZERO)) pend_d[md_issue_rd] = 1'b1;
      err_d = err_q | (pipe_sel & pend_q[pipe_rd]);
   end

   always_ff @(posedge clock or negedge ctrl_resetn) begin
      if (!ctrl_resetn) begin
         we_q    <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
         pend_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         we_q    <= we_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   assign dec_stall        = dec_valid & (pend_q[dec_rs1] | pend_q[dec_rs2] | pend_q[dec_rd]);
   assign ctrl_writeEnable = we_q;
   assign ctrl_writeReg    = wreg_q;
   assign data_writeReg    = wdata_q;
   assign err_waw          = err_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Vector-table bench for writeback_arbiter with an expected-write queue,
// plus a hand-written mid-operation reset sequence.
module tb_writeback_arbiter;

   logic        clock = 1'b0;
   logic        ctrl_resetn;
   logic        pipe_wen, md_issue, md_valid, dec_valid;
   logic [4:0]  pipe_rd, md_issue_rd, md_rd, dec_rs1, dec_rs2, dec_rd;
   logic [31:0] pipe_data, md_data;
   logic        md_ready, dec_stall, ctrl_writeEnable, err_waw;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   writeback_arbiter #(
      .FIFO_DEPTH (2),
      .NUM_REGS   (32)
   ) dut (
      .clock            (clock),
      .ctrl_resetn      (ctrl_resetn),
      .pipe_wen         (pipe_wen),
      .pipe_rd          (pipe_rd),
      .pipe_data        (pipe_data),
      .md_issue         (md_issue),
      .md_issue_rd      (md_issue_rd),
      .md_valid         (md_valid),
      .md_rd            (md_rd),
      .md_data          (md_data),
      .md_ready         (md_ready),
      .dec_valid        (dec_valid),
      .dec_rs1          (dec_rs1),
      .dec_rs2          (dec_rs2),
      .dec_rd           (dec_rd),
      .dec_stall        (dec_stall),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .err_waw          (err_waw)
   );

   typedef struct {
      logic pw; logic [4:0] prd; logic [31:0] pdat;
      logic mi; logic [4:0] mird;
      logic mv; logic [4:0] mrd; logic [31:0] mdat;
      logic dv; logic [4:0] rs1, rs2, drd;
      logic e_rdy, e_stall, e_we; logic [4:0] e_reg; logic [31:0] e_data; logic e_err;
   } vec_t;

   typedef struct {
      int idx; logic we; logic [4:0] rg; logic [31:0] d; logic err;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic vec_t mk(
      input logic pw, input logic [4:0] prd, input logic [31:0] pdat,
      input logic mi, input logic [4:0] mird,
      input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
      input logic dv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] drd,
      input logic e_rdy, input logic e_stall,
      input logic e_we, input logic [4:0] e_reg, input logic [31:0] e_data, input logic e_err);
      vec_t v;
      v.pw = pw; v.prd = prd; v.pdat = pdat; v.mi = mi; v.mird = mird;
      v.mv = mv; v.mrd = mrd; v.mdat = mdat; v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.drd = drd;
      v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_we = e_we; v.e_reg = e_reg;
      v.e_data = e_data; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive_idle();
      pipe_wen = 0; pipe_rd = 0; pipe_data = 0;
      md_issue = 0; md_issue_rd = 0;
      md_valid = 0; md_rd = 0; md_data = 0;
      dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      ctrl_resetn = 1'b0;
      drive_idle();
      #2;
      chk("reset_we",    -1, 32'(ctrl_writeEnable), 32'd0);
      chk("reset_reg",   -1, 32'(ctrl_writeReg),    32'd0);
      chk("reset_data",  -1, data_writeReg,         32'd0);
      chk("reset_err",   -1, 32'(err_waw),          32'd0);
      chk("reset_ready", -1, 32'(md_ready),         32'd0);
      @(negedge clock);
      ctrl_resetn = 1'b1;

      //            pw prd pdat          mi mird mv mrd mdat  dv rs1 rs2 drd rdy stl we reg data          err
      vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0,  0, 0,  0,    0, 0,  0,  0,  1,  0,  1, 5,  32'hDEADBEEF, 0));
      vecs.push_back(mk(1, 0, 32'h1234,     0, 0,  0, 0,  0,    0, 0,  0,  0,  1,  0,  0, 0,  0,   0));
      vecs.push_back(mk(0, 0, 0,            1, 7,  0, 0,  0,    1, 7,  0,  0,  1,  0,  0, 0,  0,   0));
      vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,  0,    1, 7,  0,  1,  1,  1,  0, 0,  0,   0));
      vecs.push_back(mk(0, 0, 0,            0, 0,  1, 7,  42,   1, 7,  0,  1,  1,  1,  1, 7,  42,  0));
      vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,  0,    1, 7,  7,  7,  1,  0,  0, 0,  0,   0));
      vecs.push_back(mk(1, 4, 44,           0, 0,  1, 3,  33,   0, 0,  0,  0,  1,  0,  1, 4,  44,  0));
      vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,  0,    0, 0,  0,  0,  1,  0,  1, 3,  33,  0));
      vecs.push_back(mk(1, 10, 100,         0, 0,  1, 20, 200,  0, 0,  0,  0,  1,  0,  1, 10, 100, 0));
      vecs.push_back(mk(1, 11, 101,         0, 0,  1, 21, 201,  0, 0,  0,  0,  1,  0,  1, 11, 101, 0));
      vecs.push_back(mk(1, 12, 102,         0, 0,  1, 22, 202,  0, 0,  0,  0,  0,  0,  1, 12, 102, 0));
      vecs.push_back(mk(1, 13, 103,         0, 0,  1, 22, 202,  0, 0,  0,  0,  0,  0,  1, 13, 103, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0,  1, 22, 202,  0, 0,  0,  0,  0,  0,  1, 20, 200, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0,  1, 22, 202,  0, 0,  0,  0,  1,  0,  1, 21, 201, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,  0,    0, 0,  0,  0,  1,  0,  1, 22, 202, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,  0,    0, 0,  0,  0,  1,  0,  0, 0,  0,   0));
      vecs.push_back(mk(0, 0, 0,            1, 9,  0, 0,  0,    0, 0,  0,  0,  1,  0,  0, 0,  0,   0));
      vecs.push_back(mk(0, 0, 0,            1, 9,  1, 9,  9,    1, 9,  0,  0,  1,  1,  1, 9,  9,   0));
      vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,  0,    1, 9,  0,  0,  1,  1,  0, 0,  0,   0));
      vecs.push_back(mk(0, 0, 0,            0, 0,  1, 9,  99,   1, 9,  0,  0,  1,  1,  1, 9,  99,  0));
      vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,  0,    1, 0,  9,  0,  1,  0,  0, 0,  0,   0));
      vecs.push_back(mk(0, 0, 0,            1, 12, 0, 0,  0,    0, 0,  0,  0,  1,  0,  0, 0,  0,   0));
      vecs.push_back(mk(1, 12, 5,           0, 0,  0, 0,  0,    1, 0,  0,  12, 1,  1,  1, 12, 5,   1));
      vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,  0,    0, 0,  0,  0,  1,  0,  0, 0,  0,   1));
      vecs.push_back(mk(0, 0, 0,            0, 0,  1, 12, 6,    0, 0,  0,  0,  1,  0,  1, 12, 6,   1));
      vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,  0,    1, 0,  0,  12, 1,  0,  0, 0,  0,   1));
      vecs.push_back(mk(0, 0, 0,            1, 0,  1, 0,  77,   0, 0,  0,  0,  1,  0,  0, 0,  0,   1));
      vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,  0,    1, 0,  0,  0,  1,  0,  0, 0,  0,   1));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         pipe_wen = vecs[i].pw; pipe_rd = vecs[i].prd; pipe_data = vecs[i].pdat;
         md_issue = vecs[i].mi; md_issue_rd = vecs[i].mird;
         md_valid = vecs[i].mv; md_rd = vecs[i].mrd; md_data = vecs[i].mdat;
         dec_valid = vecs[i].dv; dec_rs1 = vecs[i].rs1; dec_rs2 = vecs[i].rs2; dec_rd = vecs[i].drd;
         sb.push_back('{idx: i, we: vecs[i].e_we, rg: vecs[i].e_reg, d: vecs[i].e_data, err: vecs[i].e_err});
         #1;
         chk("md_ready",  i, 32'(md_ready),  32'(vecs[i].e_rdy));
         chk("dec_stall", i, 32'(dec_stall), 32'(vecs[i].e_stall));
         @(posedge clock);
         #1;
         e = sb.pop_front();
         chk("write_en", e.idx, 32'(ctrl_writeEnable), 32'(e.we));
         if (e.we) begin
            chk("write_reg",  e.idx, 32'(ctrl_writeReg), 32'(e.rg));
            chk("write_data", e.idx, data_writeReg,      e.d);
         end
         chk("err_waw", e.idx, 32'(err_waw), 32'(e.err));
      end

      // Build up two buffered results and two pending bits, then reset mid-cycle.
      @(negedge clock);
      drive_idle();
      md_issue = 1; md_issue_rd = 14;
      @(negedge clock);
      drive_idle();
      md_issue = 1; md_issue_rd = 15;
      pipe_wen = 1; pipe_rd = 1; pipe_data = 32'h1;
      md_valid = 1; md_rd = 14; md_data = 32'd14;
      @(posedge clock); #1;
      chk("rst_seq_we1", 100, 32'(ctrl_writeReg), 32'd1);
      @(negedge clock);
      drive_idle();
      pipe_wen = 1; pipe_rd = 2; pipe_data = 32'h2;
      md_valid = 1; md_rd = 15; md_data = 32'd15;
      dec_valid = 1; dec_rs1 = 14; dec_rs2 = 15;
      #1;
      chk("rst_seq_stall", 101, 32'(dec_stall), 32'd1);
      chk("rst_seq_ready", 101, 32'(md_ready),  32'd1);
      @(posedge clock); #1;
      chk("rst_seq_we2",  102, 32'(ctrl_writeReg), 32'd2);
      chk("rst_seq_full", 102, 32'(md_ready),      32'd0);
      #2;
      pipe_wen = 0; md_valid = 0;
      ctrl_resetn = 1'b0;
      #1;
      chk("midrst_we",    103, 32'(ctrl_writeEnable), 32'd0);
      chk("midrst_reg",   103, 32'(ctrl_writeReg),    32'd0);
      chk("midrst_data",  103, data_writeReg,         32'd0);
      chk("midrst_err",   103, 32'(err_waw),          32'd0);
      chk("midrst_ready", 103, 32'(md_ready),         32'd0);
      chk("midrst_stall", 103, 32'(dec_stall),        32'd0);
      @(negedge clock);
      ctrl_resetn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock); #1;
         chk("post_rst_stall", 110 + c, 32'(dec_stall), 32'd0);
         chk("post_rst_ready", 110 + c, 32'(md_ready),  32'd1);
         @(posedge clock); #1;
         chk("post_rst_we",    110 + c, 32'(ctrl_writeEnable), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
